// File: rtl/lsu_pkg.sv
// Shared types and helpers for the memory-stage load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam logic [2:0] RESULT_SRC_LOAD = 3'b001;

  // Encoding 2'b11 falls back to a word access.
  function automatic size_e decode_size(input logic [1:0] op);
    case (op)
      2'b01:   decode_size = SZ_HALF;
      2'b10:   decode_size = SZ_BYTE;
      default: decode_size = SZ_WORD;
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input size_e size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: byte_enables = 4'b0001 << offset;
      SZ_HALF: byte_enables = 4'b0011 << {offset[1], 1'b0};
      default: byte_enables = 4'b1111;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_e size, input logic [1:0] offset);
    case (size)
      SZ_HALF: is_misaligned = offset[0];
      SZ_WORD: is_misaligned = |offset;
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/half lane of a read word and sign- or zero-extends it.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  size_e       size_i,
  input  logic        sign_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection and extension.
  always_comb begin
    byte_s = rdata_i[7:0];
    half_s = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (addr_i)
      2'b00:   byte_s = rdata_i[7:0];
      2'b01:   byte_s = rdata_i[15:8];
      2'b10:   byte_s = rdata_i[23:16];
      2'b11:   byte_s = rdata_i[31:24];
      default: byte_s = rdata_i[7:0];
    endcase
    case (size_i)
      SZ_BYTE: data_o = {{24{sign_i & byte_s[7]}}, byte_s};
      SZ_HALF: data_o = {{16{sign_i & half_s[15]}}, half_s};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage LSU: issues one data-bus transaction per aligned load/store,
// stalls the pipeline while it is outstanding and holds the last load result.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              RegWriteM,
  input  logic              MemWriteM,
  input  logic [2:0]        ResultSrcM,
  input  logic [1:0]        Byte_Half_OpM,
  input  logic              signM,
  input  logic [ADDR_W-1:0] ALUResultM,
  input  logic [DATA_W-1:0] WriteDataM,
  output logic              DReq,
  output logic              DWe,
  output logic [ADDR_W-1:0] DAddr,
  output logic [3:0]        DBe,
  output logic [DATA_W-1:0] DWData,
  input  logic [DATA_W-1:0] DRData,
  input  logic              DAck,
  output logic              StallM,
  output logic [DATA_W-1:0] ReadDataM,
  output logic              MisalignM
);

  state_e            state_q, state_d;
  logic              dreq_q, dreq_d;
  logic              dwe_q, dwe_d;
  logic [ADDR_W-1:0] daddr_q, daddr_d;
  logic [3:0]        dbe_q, dbe_d;
  logic [DATA_W-1:0] dwdata_q, dwdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              load_q, load_d;
  size_e             size_q, size_d;
  logic [1:0]        off_q, off_d;
  logic              sign_q, sign_d;

  logic              is_load_s;
  logic              access_s;
  logic              go_s;
  size_e             size_s;
  logic [DATA_W-1:0] wdata_s;
  logic [DATA_W-1:0] aligned_s;
  logic              unused_s;

  assign unused_s  = RegWriteM;
  assign is_load_s = (ResultSrcM == RESULT_SRC_LOAD);
  assign access_s  = MemWriteM | is_load_s;
  assign size_s    = decode_size(Byte_Half_OpM);
  assign MisalignM = access_s & is_misaligned(size_s, ALUResultM[1:0]);
  assign go_s      = access_s & ~MisalignM;
  assign StallM    = ((state_q == IDLE) & go_s) | (state_q == REQ);

  assign DReq      = dreq_q;
  assign DWe       = dwe_q;
  assign DAddr     = daddr_q;
  assign DBe       = dbe_q;
  assign DWData    = dwdata_q;
  assign ReadDataM = rdata_q;

  // Replicate store data across every lane the size could address.
  always_comb begin
    case (size_s)
      SZ_BYTE: wdata_s = {4{WriteDataM[7:0]}};
      SZ_HALF: wdata_s = {2{WriteDataM[15:0]}};
      default: wdata_s = WriteDataM;
    endcase
  end

  // Access attributes are latched at issue so formatting does not depend on the pipeline inputs.
  load_align u_load_align (
    .rdata_i (DRData),
    .addr_i  (off_q),
    .size_i  (size_q),
    .sign_i  (sign_q),
    .data_o  (aligned_s)
  );

  // Next-state and next-output logic of the transaction FSM.
  always_comb begin
    state_d  = state_q;
    dreq_d   = dreq_q;
    dwe_d    = dwe_q;
    daddr_d  = daddr_q;
    dbe_d    = dbe_q;
    dwdata_d = dwdata_q;
    rdata_d  = rdata_q;
    load_d   = load_q;
    size_d   = size_q;
    off_d    = off_q;
    sign_d   = sign_q;
    case (state_q)
      IDLE: begin
        if (go_s) begin
          state_d  = REQ;
          dreq_d   = 1'b1;
          dwe_d    = MemWriteM;
          daddr_d  = {ALUResultM[ADDR_W-1:2], 2'b00};
          dbe_d    = byte_enables(size_s, ALUResultM[1:0]);
          dwdata_d = wdata_s;
          load_d   = ~MemWriteM;
          size_d   = size_s;
          off_d    = ALUResultM[1:0];
          sign_d   = signM;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (DAck) begin
          state_d = DONE;
          dreq_d  = 1'b0;
          if (load_q) begin
            rdata_d = aligned_s;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          state_d = REQ;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        dreq_d  = 1'b0;
      end
    endcase
  end

  // State and registered bus/result outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      dreq_q   <= 1'b0;
      dwe_q    <= 1'b0;
      daddr_q  <= {ADDR_W{1'b0}};
      dbe_q    <= 4'b0000;
      dwdata_q <= {DATA_W{1'b0}};
      rdata_q  <= {DATA_W{1'b0}};
      load_q   <= 1'b0;
      size_q   <= SZ_WORD;
      off_q    <= 2'b00;
      sign_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dreq_q   <= dreq_d;
      dwe_q    <= dwe_d;
      daddr_q  <= daddr_d;
      dbe_q    <= dbe_d;
      dwdata_q <= dwdata_d;
      rdata_q  <= rdata_d;
      load_q   <= load_d;
      size_q   <= size_d;
      off_q    <= off_d;
      sign_q   <= sign_d;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed vector table, reset/ack corner
// sequences and randomized transactions against an arithmetic reference model.
module tb_mem_stage_lsu;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        RegWriteM, MemWriteM, signM, DAck;
  logic [2:0]  ResultSrcM;
  logic [1:0]  Byte_Half_OpM;
  logic [31:0] ALUResultM, WriteDataM, DRData;
  logic        DReq, DWe, StallM, MisalignM;
  logic [31:0] DAddr, DWData, ReadDataM;
  logic [3:0]  DBe;

  int total = 0;
  int bad   = 0;
  logic [31:0] rd_model;

  typedef struct {
    logic        we;
    logic [2:0]  rs;
    logic [1:0]  op;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    logic        exp_mis;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [31:0] exp_rd;
  } vec_t;

  mem_stage_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .CLK(CLK), .RST_N(RST_N), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM), .Byte_Half_OpM(Byte_Half_OpM), .signM(signM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .DReq(DReq), .DWe(DWe),
    .DAddr(DAddr), .DBe(DBe), .DWData(DWData), .DRData(DRData), .DAck(DAck),
    .StallM(StallM), .ReadDataM(ReadDataM), .MisalignM(MisalignM)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] rs, input logic [1:0] op,
                              input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int lat, input logic exp_mis,
                              input logic [3:0] exp_be, input logic [31:0] exp_wd,
                              input logic [31:0] exp_rd);
    vec_t v;
    v.we = we; v.rs = rs; v.op = op; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.lat = lat; v.exp_mis = exp_mis; v.exp_be = exp_be;
    v.exp_wd = exp_wd; v.exp_rd = exp_rd;
    return v;
  endfunction

  task automatic set_idle();
    MemWriteM = 1'b0; ResultSrcM = 3'b000; Byte_Half_OpM = 2'b00; signM = 1'b0;
    RegWriteM = 1'b0; DAck = 1'b0;
  endtask

  // Presents one instruction to the stage, plays the memory side and checks the response.
  task automatic run_txn(input vec_t v, input string tag);
    logic access;
    int   stalls;
    access = v.we | (v.rs == 3'b001);
    stalls = 0;
    @(posedge CLK); #1;
    MemWriteM = v.we; ResultSrcM = v.rs; Byte_Half_OpM = v.op; signM = v.sgn;
    ALUResultM = v.addr; WriteDataM = v.wdata; RegWriteM = ~v.we;
    #1;
    chk({tag, ".misalign"}, {31'd0, MisalignM}, {31'd0, v.exp_mis});
    if (!access || v.exp_mis) begin
      for (int i = 0; i < 2; i++) begin
        chk({tag, ".nostall"}, {31'd0, StallM}, 32'd0);
        chk({tag, ".noreq"}, {31'd0, DReq}, 32'd0);
        @(posedge CLK); #1;
      end
      chk({tag, ".rdhold"}, ReadDataM, v.exp_rd);
    end else begin
      if (StallM) stalls++;
      for (int n = 1; n <= v.lat; n++) begin
        @(posedge CLK); #1;
        chk({tag, ".dreq"}, {31'd0, DReq}, 32'd1);
        chk({tag, ".dwe"}, {31'd0, DWe}, {31'd0, v.we});
        chk({tag, ".daddr"}, DAddr, v.addr & 32'hFFFF_FFFC);
        chk({tag, ".dbe"}, {28'd0, DBe}, {28'd0, v.exp_be});
        if (v.we) chk({tag, ".dwdata"}, DWData, v.exp_wd);
        if (StallM) stalls++;
        DAck   = (n == v.lat);
        DRData = (n == v.lat) ? v.rdata : $urandom;
      end
      @(posedge CLK); #1;
      DAck = 1'b0;
      chk({tag, ".done_dreq"}, {31'd0, DReq}, 32'd0);
      chk({tag, ".done_stall"}, {31'd0, StallM}, 32'd0);
      chk({tag, ".readdata"}, ReadDataM, v.exp_rd);
      chk({tag, ".stallcycles"}, stalls, v.lat + 1);
    end
    set_idle();
  endtask

  // Reference model: plain arithmetic on sizes, offsets and masks.
  task automatic gen_random(output vec_t v);
    int          nb, sh, kind;
    logic        access, mis;
    logic [31:0] mask, val;
    kind    = $urandom_range(0, 9);
    v.we    = (kind >= 1 && kind <= 4) || kind == 9;
    v.rs    = (kind >= 5) ? 3'b001 : 3'($urandom_range(2, 7));
    v.op    = 2'($urandom_range(0, 3));
    v.sgn   = 1'($urandom_range(0, 1));
    v.addr  = $urandom;
    v.wdata = $urandom;
    v.rdata = $urandom;
    v.lat   = $urandom_range(1, 4);
    nb      = (v.op == 2'b01) ? 2 : (v.op == 2'b10) ? 1 : 4;
    sh      = int'(v.addr % 32'd4);
    access  = v.we | (v.rs == 3'b001);
    mis     = access && ((v.addr % nb) != 0);
    v.exp_mis = mis;
    v.exp_be  = 4'(((1 << nb) - 1) << sh);
    v.exp_wd  = (nb == 1) ? {24'd0, v.wdata[7:0]} * 32'h0101_0101 :
                (nb == 2) ? {16'd0, v.wdata[15:0]} * 32'h0001_0001 : v.wdata;
    mask = (nb == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * nb)) - 32'd1;
    val  = (v.rdata >> (8 * sh)) & mask;
    if (v.sgn && nb < 4 && val[8 * nb - 1]) val = val | ~mask;
    if (access && !mis && !v.we) rd_model = val;
    v.exp_rd = rd_model;
  endtask

  initial begin
    vec_t tbl[13];
    vec_t v;

    set_idle();
    RST_N = 1'b0; ALUResultM = 32'd0; WriteDataM = 32'd0; DRData = 32'd0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset.dreq", {31'd0, DReq}, 32'd0);
    chk("reset.dwe", {31'd0, DWe}, 32'd0);
    chk("reset.daddr", DAddr, 32'd0);
    chk("reset.dbe", {28'd0, DBe}, 32'd0);
    chk("reset.dwdata", DWData, 32'd0);
    chk("reset.readdata", ReadDataM, 32'd0);
    chk("reset.stall", {31'd0, StallM}, 32'd0);
    #2 RST_N = 1'b1;

    //          we   rs      op     sgn  addr          wdata         rdata         lat mis be       wd            rd
    tbl[0]  = mk(1'b1, 3'b000, 2'b10, 1'b0, 32'h0000_1003, 32'h0000_00A5, 32'h0,        1, 1'b0, 4'b1000, 32'hA5A5_A5A5, 32'h0000_0000);
    tbl[1]  = mk(1'b0, 3'b001, 2'b01, 1'b1, 32'h0000_2002, 32'h0,        32'h8001_1234, 1, 1'b0, 4'b1100, 32'h0,        32'hFFFF_8001);
    tbl[2]  = mk(1'b0, 3'b001, 2'b01, 1'b0, 32'h0000_2002, 32'h0,        32'h8001_1234, 1, 1'b0, 4'b1100, 32'h0,        32'h0000_8001);
    tbl[3]  = mk(1'b0, 3'b001, 2'b10, 1'b0, 32'h0000_2001, 32'h0,        32'h0000_F000, 1, 1'b0, 4'b0010, 32'h0,        32'h0000_00F0);
    tbl[4]  = mk(1'b0, 3'b001, 2'b10, 1'b1, 32'h0000_2001, 32'h0,        32'h0000_F000, 1, 1'b0, 4'b0010, 32'h0,        32'hFFFF_FFF0);
    tbl[5]  = mk(1'b0, 3'b001, 2'b00, 1'b0, 32'h0000_3000, 32'h0,        32'hDEAD_BEEF, 3, 1'b0, 4'b1111, 32'h0,        32'hDEAD_BEEF);
    tbl[6]  = mk(1'b1, 3'b000, 2'b00, 1'b0, 32'h0000_1002, 32'h55,       32'h0,        1, 1'b1, 4'b0000, 32'h0,        32'hDEAD_BEEF);
    tbl[7]  = mk(1'b0, 3'b001, 2'b01, 1'b1, 32'h0000_2001, 32'h0,        32'hFFFF_FFFF, 1, 1'b1, 4'b0000, 32'h0,        32'hDEAD_BEEF);
    tbl[8]  = mk(1'b1, 3'b010, 2'b01, 1'b0, 32'h0000_1006, 32'h1234_ABCD, 32'h0,        2, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'hDEAD_BEEF);
    tbl[9]  = mk(1'b1, 3'b001, 2'b00, 1'b0, 32'h0000_4000, 32'h1122_3344, 32'h9999_9999, 1, 1'b0, 4'b1111, 32'h1122_3344, 32'hDEAD_BEEF);
    tbl[10] = mk(1'b0, 3'b001, 2'b11, 1'b1, 32'h0000_4004, 32'h0,        32'h0F0F_0F0F, 2, 1'b0, 4'b1111, 32'h0,        32'h0F0F_0F0F);
    tbl[11] = mk(1'b0, 3'b001, 2'b10, 1'b1, 32'h0000_2003, 32'h0,        32'h7F00_0000, 1, 1'b0, 4'b1000, 32'h0,        32'h0000_007F);
    tbl[12] = mk(1'b0, 3'b011, 2'b00, 1'b0, 32'h0000_7000, 32'h0,        32'h0,        1, 1'b0, 4'b0000, 32'h0,        32'h0000_007F);

    for (int i = 0; i < 13; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // A stray acknowledge with no access in flight must be ignored.
    @(posedge CLK); #1;
    DAck = 1'b1; DRData = 32'h1234_5678;
    @(posedge CLK); #1;
    DAck = 1'b0;
    chk("strayack.dreq", {31'd0, DReq}, 32'd0);
    chk("strayack.stall", {31'd0, StallM}, 32'd0);
    chk("strayack.readdata", ReadDataM, 32'h0000_007F);

    // Reset in the middle of an outstanding load abandons it.
    @(posedge CLK); #1;
    MemWriteM = 1'b0; ResultSrcM = 3'b001; Byte_Half_OpM = 2'b00; ALUResultM = 32'h0000_5000;
    @(posedge CLK); #1;
    chk("midreset.req_before", {31'd0, DReq}, 32'd1);
    #2 RST_N = 1'b0;
    #1;
    chk("midreset.dreq", {31'd0, DReq}, 32'd0);
    chk("midreset.readdata", ReadDataM, 32'd0);
    chk("midreset.daddr", DAddr, 32'd0);
    set_idle();
    #2 RST_N = 1'b1;
    run_txn(mk(1'b0, 3'b001, 2'b00, 1'b0, 32'h0000_6000, 32'h0, 32'hCAFE_F00D, 2,
               1'b0, 4'b1111, 32'h0, 32'hCAFE_F00D), "postreset");

    rd_model = 32'hCAFE_F00D;
    for (int i = 0; i < 150; i++) begin
      gen_random(v);
      run_txn(v, $sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
